dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-ported, word-organised data/instruction memory between the instruction-fetch port (I) and the load/store port (D).
- Sits between the core pipeline and the memory array. Handles:
  - request arbitration;
  - byte-enable generation for SB/SH/SW;
  - load alignment and extension for LB/LH/LW/LBU/LHU;
  - misalignment detection.
- The memory has a 1-cycle synchronous read and a byte-enabled synchronous write.

Parameters:
- ADDR_W, 8, byte-address width. The memory holds 2^(ADDR_W-2) words.
- MAX_DSTREAK, 4, number of consecutive D grants allowed while I is waiting before I is forced.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch byte address; must be word-aligned
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetch word
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_f3  in  3  funct3 (load or store width)
- d_addr  in  ADDR_W  byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  D request accepted
- d_rvalid  out  1  load data valid; also pulses for a store ack
- d_rdata  out  32  extended load data; 0 for a store
- d_err  out  1  misaligned access, pulsed with d_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  lane-replicated write data
- mem_rdata  in  32  read word, valid the cycle after mem_en
- perf_i_stall  out  16  I-waiting cycle count; optional feature
- perf_d_stall  out  16  D-waiting cycle count; optional feature

Behaviour:
- Reset (async): all outputs 0, streak counter 0, response owner NONE, perf counters 0.
- Pipelining: one access is issued per cycle at most; there is one outstanding response.
  - Grant in cycle N: mem_en and the memory outputs are combinational from the granted request in cycle N.
  - The response (rvalid/rdata) arrives in cycle N+1.
  - A new grant in cycle N+1 is legal, so back-to-back throughput is 1 per cycle.
- Owner register: records I, D or D_ERR for cycle N+1.
- Arbitration:
  - If only one port requests, it is granted.
  - If both request, D wins unless streak == MAX_DSTREAK, in which case I wins.
  - Streak increments on a D grant while i_req is high.
  - Streak clears on any I grant, or on any cycle where i_req is low.
  - The streak counter saturates at MAX_DSTREAK.
- Requesters hold req/addr/data stable until they see gnt. gnt is a single-cycle pulse.
- Store byte enables:
  - SB: be = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - mem_we = 1. Stores are acked with d_rvalid in N+1 and d_rdata = 0.
- Loads: mem_be = 0000. The response selects a byte or halfword by the registered addr[1:0]:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.
  - Other f3: treated as LW.
- Misalignment: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - The request is granted but mem_en is held 0 (no memory access, no write).
  - N+1: d_rvalid = 1, d_err = 1, d_rdata = 0.
- i_addr[1:0] is ignored: the word is fetched.
- Simultaneous response and new grant: the response goes to the registered owner, and the new grant's owner overwrites the register at the clock edge.
- Reset mid-operation: the outstanding response is dropped. No rvalid is produced after reset is released.

Optional Feature:
- DMEM_ARB_PERF_EN
  - Defined:
    - perf_i_stall increments each cycle with i_req & ~i_gnt.
    - perf_d_stall increments each cycle with d_req & ~d_gnt.
    - Both saturate at 16'hFFFF and clear on reset.
  - Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared defines file carries:
  - F3 codes: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010;
  - owner encoding: NONE/I/D/D_ERR.
- Sub-module mem_load_align: combinational extract and extend from (word, addr[1:0], f3) to 32-bit data.
- Arbitration, store-lane logic and response registers stay in dmem_arbiter.

Test Plan:
- Only I requests addr 0x08 with mem word 2 = 0x00000019 -> i_gnt in cycle 0; i_rvalid = 1 with i_rdata = 0x00000019 in cycle 1.
- SB addr 0x05, wdata = 0x000000A5 -> mem_be = 0010, mem_addr = 1, mem_wdata = 0xA5A5A5A5. A following LB 0x05 -> d_rdata = 0xFFFFFFA5; LBU 0x05 -> 0x000000A5.
- Both ports request continuously with MAX_DSTREAK = 4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no two responses in the same cycle.
- LW addr 0x06 -> d_gnt = 1, mem_en = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0; memory unchanged.
- D grant, then rst asserted in the response cycle -> d_rvalid = 0, all outputs 0, streak and owner cleared.
- With DMEM_ARB_PERF_EN, I blocked for 3 cycles -> perf_i_stall = 3. Without the macro -> 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 width codes,
// response-owner encoding and the misalignment rule.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_I     = 2'd1,
        OWN_D     = 2'd2,
        OWN_D_ERR = 2'd3
    } owner_e;

    // Access size lives in f3[1:0]; any code that is not byte or half acts as a word.
    function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] addrLo);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addrLo[0];
            default: return addrLo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_f3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_f3, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_load_align.sv
// Load alignment: picks the addressed byte/halfword from a memory word and
// sign- or zero-extends it according to funct3.
module mem_load_align
    import dmem_arbiter_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addrLo_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word_i[{addrLo_i, 3'b000} +: 8];
        halfSel = addrLo_i[1] ? word_i[31:16] : word_i[15:0];
        case (f3_i)
            F3_LB:   data_o = {{24{byteSel[7]}}, byteSel};
            F3_LH:   data_o = {{16{halfSel[15]}}, halfSel};
            F3_LBU:  data_o = {24'd0, byteSel};
            F3_LHU:  data_o = {16'd0, halfSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-ported word memory between fetch (I) and load/store (D).
// Optional stall counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus,
    output logic [15:0]   perf_i_stall,
    output logic [15:0]   perf_d_stall
);

    localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    logic                iGnt, dGnt, dMis, dAccess, dStore;
    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              owner_q, owner_d;
    logic [1:0]          dAddrLo_q, dAddrLo_d;
    logic [2:0]          dF3_q, dF3_d;
    logic                dWe_q, dWe_d;
    logic [31:0]         loadData;
    logic [1:0]          unusedAddrBits;

    assign unusedAddrBits = bus.i_addr[1:0];

    // D normally wins; once it has starved a waiting I for MAX_DSTREAK grants, I goes next.
    always_comb begin
        dMis     = isMisaligned(bus.d_f3, bus.d_addr[1:0]);
        dGnt     = ~rst & bus.d_req & (~bus.i_req | (streak_q != STREAK_MAX));
        iGnt     = ~rst & bus.i_req & ~dGnt;
        dAccess  = dGnt & ~dMis;
        dStore   = dAccess & bus.d_we;

        streak_d = streak_q;
        if (!bus.i_req || iGnt)
            streak_d = '0;
        else if (dGnt && streak_q != STREAK_MAX)
            streak_d = streak_q + 1'b1;

        owner_d   = OWN_NONE;
        dAddrLo_d = dAddrLo_q;
        dF3_d     = dF3_q;
        dWe_d     = dWe_q;
        if (iGnt) begin
            owner_d = OWN_I;
        end else if (dGnt) begin
            owner_d   = dMis ? OWN_D_ERR : OWN_D;
            dAddrLo_d = bus.d_addr[1:0];
            dF3_d     = bus.d_f3;
            dWe_d     = bus.d_we;
        end
    end

    // Memory strobes follow the grant in the same cycle; a misaligned D grant touches nothing.
    always_comb begin
        bus.mem_en    = iGnt | dAccess;
        bus.mem_we    = dStore;
        bus.mem_addr  = '0;
        bus.mem_be    = 4'b0000;
        bus.mem_wdata = 32'd0;
        if (iGnt)
            bus.mem_addr = bus.i_addr[ADDR_W-1:2];
        else if (dAccess)
            bus.mem_addr = bus.d_addr[ADDR_W-1:2];
        if (dStore) begin
            case (bus.d_f3[1:0])
                2'b00: begin
                    bus.mem_be    = 4'b0001 << bus.d_addr[1:0];
                    bus.mem_wdata = {4{bus.d_wdata[7:0]}};
                end
                2'b01: begin
                    bus.mem_be    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                    bus.mem_wdata = {2{bus.d_wdata[15:0]}};
                end
                default: begin
                    bus.mem_be    = 4'b1111;
                    bus.mem_wdata = bus.d_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q  <= '0;
            owner_q   <= OWN_NONE;
            dAddrLo_q <= 2'b00;
            dF3_q     <= 3'b000;
            dWe_q     <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            owner_q   <= owner_d;
            dAddrLo_q <= dAddrLo_d;
            dF3_q     <= dF3_d;
            dWe_q     <= dWe_d;
        end
    end

    mem_load_align u_align (
        .word_i   (bus.mem_rdata),
        .addrLo_i (dAddrLo_q),
        .f3_i     (dF3_q),
        .data_o   (loadData)
    );

    assign bus.i_gnt    = iGnt;
    assign bus.d_gnt    = dGnt;
    assign bus.i_rvalid = (owner_q == OWN_I);
    assign bus.i_rdata  = (owner_q == OWN_I) ? bus.mem_rdata : 32'd0;
    assign bus.d_rvalid = (owner_q == OWN_D) || (owner_q == OWN_D_ERR);
    assign bus.d_err    = (owner_q == OWN_D_ERR);
    assign bus.d_rdata  = (owner_q == OWN_D && !dWe_q) ? loadData : 32'd0;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perfI_q, perfD_q;

    // Stall counters saturate rather than wrap so a long run never reads as short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfI_q <= 16'd0;
            perfD_q <= 16'd0;
        end else begin
            if (bus.i_req && !iGnt && perfI_q != 16'hFFFF)
                perfI_q <= perfI_q + 16'd1;
            if (bus.d_req && !dGnt && perfD_q != 16'hFFFF)
                perfD_q <= perfD_q + 16'd1;
        end
    end

    assign perf_i_stall = perfI_q;
    assign perf_d_stall = perfD_q;
`else
    assign perf_i_stall = 16'd0;
    assign perf_d_stall = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic scored against a behavioural memory/arbitration model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int MAX_DSTREAK = 4;
    localparam int WORDS       = 64;
`ifdef DMEM_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] perfI, perfD;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_DSTREAK(MAX_DSTREAK)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .perf_i_stall (perfI),
        .perf_d_stall (perfD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array driven purely by the DUT's strobes.
    logic [31:0] initMem [WORDS];
    logic [31:0] tbMem   [WORDS];
    logic [31:0] refMem  [WORDS];
    logic        loadMem;
    logic [31:0] memRdata;

    assign bus.mem_rdata = memRdata;

    always @(posedge clk) begin
        if (loadMem) begin
            for (int k = 0; k < WORDS; k++) tbMem[k] <= initMem[k];
        end else if (bus.mem_en) begin
            memRdata <= tbMem[bus.mem_addr];
            if (bus.mem_we)
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) tbMem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    int          checks, errors;
    int          dStreak, respKind, perfIModel, perfDModel;
    logic [31:0] respData;
    bit          lastIGnt, lastDGnt;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [7:0] ia, input bit dr, input bit we,
                                 input logic [2:0] f3, input logic [7:0] da, input logic [31:0] wd);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_f3    = f3;
        bus.d_addr  = da;
        bus.d_wdata = wd;
    endtask

    function automatic logic [31:0] loadValue(input logic [31:0] w, input int off, input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (8 * off)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // One clock of model evaluation: check responses and strobes, then advance the model.
    task automatic evalCycle();
        bit          expI, expD, mis;
        int          sz, off, idx, newKind;
        logic [31:0] expBe, expWd, newData;
        #1;
        if (rst) begin
            respKind   = 0;
            dStreak    = 0;
            perfIModel = 0;
            perfDModel = 0;
        end
        checkOutput("i_rvalid", bus.i_rvalid, respKind == 1);
        if (respKind == 1) checkOutput("i_rdata", bus.i_rdata, respData);
        checkOutput("d_rvalid", bus.d_rvalid, respKind >= 2);
        checkOutput("d_err", bus.d_err, respKind == 3);
        if (respKind >= 2) checkOutput("d_rdata", bus.d_rdata, respData);
        checkOutput("one_resp", bus.i_rvalid & bus.d_rvalid, 0);
        checkOutput("perf_i", perfI, PERF_ON ? perfIModel : 0);
        checkOutput("perf_d", perfD, PERF_ON ? perfDModel : 0);

        if (rst) begin
            expI = 0; expD = 0;
        end else if (bus.i_req && bus.d_req) begin
            expD = dStreak < MAX_DSTREAK;
            expI = !expD;
        end else begin
            expI = bus.i_req;
            expD = bus.d_req;
        end
        checkOutput("i_gnt", bus.i_gnt, expI);
        checkOutput("d_gnt", bus.d_gnt, expD);

        sz      = (bus.d_f3[1:0] == 2'b00) ? 1 : (bus.d_f3[1:0] == 2'b01) ? 2 : 4;
        off     = int'(bus.d_addr) % 4;
        mis     = (int'(bus.d_addr) % sz) != 0;
        idx     = int'(bus.d_addr) / 4;
        newKind = 0;
        newData = 32'd0;
        if (expI) begin
            checkOutput("mem_en", bus.mem_en, 1);
            checkOutput("mem_we", bus.mem_we, 0);
            checkOutput("mem_be", bus.mem_be, 0);
            checkOutput("mem_addr", bus.mem_addr, int'(bus.i_addr) / 4);
            newKind = 1;
            newData = refMem[int'(bus.i_addr) / 4];
        end else if (expD && mis) begin
            checkOutput("mem_en", bus.mem_en, 0);
            checkOutput("mem_we", bus.mem_we, 0);
            newKind = 3;
        end else if (expD) begin
            checkOutput("mem_en", bus.mem_en, 1);
            checkOutput("mem_we", bus.mem_we, bus.d_we);
            checkOutput("mem_addr", bus.mem_addr, idx);
            newKind = 2;
            if (bus.d_we) begin
                expBe = (sz == 1) ? (32'd1 << off) : (sz == 2) ? (32'd3 << off) : 32'd15;
                expWd = (sz == 1) ? 32'h01010101 * bus.d_wdata[7:0]
                      : (sz == 2) ? 32'h00010001 * bus.d_wdata[15:0] : bus.d_wdata;
                checkOutput("mem_be", bus.mem_be, expBe);
                checkOutput("mem_wdata", bus.mem_wdata, expWd);
                for (int b = 0; b < 4; b++)
                    if (expBe[b]) refMem[idx][8*b +: 8] = expWd[8*b +: 8];
            end else begin
                checkOutput("mem_be", bus.mem_be, 0);
                newData = loadValue(refMem[idx], off, bus.d_f3);
            end
        end else begin
            checkOutput("mem_en", bus.mem_en, 0);
            checkOutput("mem_we", bus.mem_we, 0);
        end

        if (!rst) begin
            if (bus.i_req && !expI && perfIModel < 65535) perfIModel++;
            if (bus.d_req && !expD && perfDModel < 65535) perfDModel++;
            if (!bus.i_req || expI) dStreak = 0;
            else if (expD && dStreak < MAX_DSTREAK) dStreak++;
        end
        respKind = newKind;
        respData = newData;
        lastIGnt = expI;
        lastDGnt = expD;
        @(negedge clk);
    endtask

    logic [9:0]  seqI;
    bit          rIr, rDr, rWe;
    logic [7:0]  rIa, rDa;
    logic [2:0]  rF3;
    logic [31:0] rWd;
    int          pick;

    initial begin
        checks = 0; errors = 0;
        dStreak = 0; respKind = 0; respData = 0;
        perfIModel = 0; perfDModel = 0;
        lastIGnt = 0; lastDGnt = 0;
        for (int k = 0; k < WORDS; k++) begin
            initMem[k] = $urandom;
            refMem[k]  = initMem[k];
        end
        initMem[2] = 32'h00000019;
        refMem[2]  = 32'h00000019;
        rst     = 1'b1;
        loadMem = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        loadMem = 1'b0;

        // Reset holds every output low even with requests present.
        applyStimulus(1, 8'h08, 1, 0, F3_LW, 8'h00, 0);
        #1;
        checkOutput("rst_i_gnt", bus.i_gnt, 0);
        checkOutput("rst_d_gnt", bus.d_gnt, 0);
        checkOutput("rst_mem_en", bus.mem_en, 0);
        checkOutput("rst_rvalid", bus.i_rvalid | bus.d_rvalid, 0);
        checkOutput("rst_perf_i", perfI, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Lone fetch from 0x08.
        applyStimulus(1, 8'h08, 0, 0, 0, 0, 0);
        #1 checkOutput("fetch_gnt", bus.i_gnt, 1);
        evalCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("fetch_data", bus.i_rdata, 32'h00000019);
        evalCycle();

        // SB then LB / LBU at 0x05.
        applyStimulus(0, 0, 1, 1, F3_SB, 8'h05, 32'h000000A5);
        #1;
        checkOutput("sb_be", bus.mem_be, 4'b0010);
        checkOutput("sb_addr", bus.mem_addr, 1);
        checkOutput("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        evalCycle();
        applyStimulus(0, 0, 1, 0, F3_LB, 8'h05, 0);
        evalCycle();
        applyStimulus(0, 0, 1, 0, F3_LBU, 8'h05, 0);
        #1 checkOutput("lb_data", bus.d_rdata, 32'hFFFFFFA5);
        evalCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("lbu_data", bus.d_rdata, 32'h000000A5);
        evalCycle();

        // Both ports saturate the arbiter: D,D,D,D,I,D,D,D,D,I.
        seqI = 10'b1000010000;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 8'(4 * c), 1, 0, F3_LW, 8'(4 * c + 64), 0);
            evalCycle();
            checkOutput("streak_seq", lastIGnt, seqI[c]);
        end

        // Misaligned LW and SW at 0x06: granted, no memory access, error response.
        applyStimulus(0, 0, 1, 0, F3_LW, 8'h06, 0);
        #1;
        checkOutput("mis_gnt", bus.d_gnt, 1);
        checkOutput("mis_mem_en", bus.mem_en, 0);
        evalCycle();
        applyStimulus(0, 0, 1, 1, F3_SW, 8'h06, 32'hDEADBEEF);
        #1;
        checkOutput("mis_err", bus.d_err, 1);
        checkOutput("mis_rdata", bus.d_rdata, 0);
        evalCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        evalCycle();
        checkOutput("mis_mem_kept", tbMem[1], refMem[1]);

        // Reset arriving in the response cycle drops the response.
        applyStimulus(0, 0, 1, 0, F3_LW, 8'h10, 0);
        evalCycle();
        rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid", bus.d_rvalid, 0);
        checkOutput("midrst_gnt", bus.d_gnt, 0);
        evalCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        evalCycle();

        // Fetch blocked for three D grants in a row.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 8'h20, 1, 0, F3_LW, 8'h24, 0);
            evalCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("perf_i_three", perfI, PERF_ON ? 3 : 0);
        evalCycle();

        // Randomized traffic; requesters hold until granted.
        rIr = 0; rDr = 0; rWe = 0; rIa = 0; rDa = 0; rF3 = 0; rWd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!rIr || lastIGnt) begin
                rIr = $urandom_range(0, 99) < 60;
                rIa = 8'($urandom_range(0, 255));
            end
            if (!rDr || lastDGnt) begin
                rDr  = $urandom_range(0, 99) < 55;
                rWe  = $urandom_range(0, 1) == 1;
                pick = rWe ? $urandom_range(0, 2) : $urandom_range(0, 4);
                case (pick)
                    0: rF3 = F3_LB;
                    1: rF3 = F3_LH;
                    2: rF3 = F3_LW;
                    3: rF3 = F3_LBU;
                    default: rF3 = F3_LHU;
                endcase
                rDa = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 99) < 75)
                    rDa = (rF3[1:0] == 2'b00) ? rDa : (rF3[1:0] == 2'b01) ? (rDa & 8'hFE) : (rDa & 8'hFC);
                rWd = $urandom;
            end
            applyStimulus(rIr, rIa, rDr, rWe, rF3, rDa, rWd);
            evalCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        evalCycle();
        for (int k = 0; k < WORDS; k += 9) checkOutput("final_mem", tbMem[k], refMem[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
